demux_1_4_stream: RTL
=====================

// Module: demux_1_4_stream
// PURPOSE
// - Inverse of the 4:1 data mux: routes one W-bit input word to one of four output channels chosen by a 2-bit select.
// - Valid/ready handshake on every side; each channel has a one-entry output register, so latency is 1 cycle.
// - Per-channel 8-bit transfer counters for debug.
// - Sits between a single producer and four independent consumers.
// PARAMETERS
// - W      4  data width per word; even, >= 2
// - CNT_W  8  width of each per-channel transfer counter
// PORTS
// - clk        in   1        rising-edge clock, the only clock
// - rst        in   1        synchronous reset, active-high
// - in_valid   in   1        producer presents in_data/in_sel
// - in_ready   out  1        word accepted on in_valid && in_ready
// - in_data    in   W        payload word
// - in_sel     in   2        destination channel 0..3
// - out_valid  out  4        bit k: channel k register holds a word
// - out_ready  in   4        bit k: consumer k takes word on out_valid[k] && out_ready[k]
// - out_data   out  4*W      channel k word at [k*W +: W]
// - out_cnt    out  4*CNT_W  channel k delivered-word count at [k*CNT_W +: CNT_W]
// BEHAVIOUR
// - Reset: one clk edge with rst=1 forces
//   - out_valid=0, out_data=0, out_cnt=0;
//   - in_ready=0 while rst=1.
//   - A reset mid-transfer discards all held words without delivering them.
// - Per channel k:
//   - Two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
//   - Load condition: ld[k] = in_valid && in_ready && in_sel==k.
//   - Drain condition: dr[k] = out_valid[k] && out_ready[k].
//   - EMPTY -> FULL on ld[k]; out_data[k] <= in_data.
//   - FULL -> EMPTY on dr[k] && !ld[k].
//   - FULL stays FULL on dr[k] && ld[k]: register reloads with the new word, no bubble.
//   - FULL && !dr[k]: out_data[k] held stable; out_valid[k] stays high.
// - in_ready (combinational):
//   - in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]).
//   - It depends only on the selected channel; a stall on one channel never blocks words bound for another.
// - Latency: a word accepted at edge t appears on its channel after edge t, i.e. out_valid high in cycle t+1.
// - Channel independence:
//   - Channels not selected drain independently in the same cycle as a load.
//   - Up to one load and four drains per cycle.
// - Counters:
//   - out_cnt[k] increments by 1 on each dr[k].
//   - Wraps modulo 2**CNT_W (255 -> 0); no saturation.
// - Producer rules:
//   - in_data and in_sel are sampled only when in_valid && in_ready.
//   - in_sel may change every cycle.
// - No word is ever duplicated, dropped (outside reset), or reordered within a channel.
// STRUCTURE
// - Package demux_pkg:
//   - localparam N_CH = 4; typedef logic [1:0] ch_sel_t;
//   - typedef enum logic {CH_EMPTY, CH_FULL} ch_state_t.
// - Sub-module demux_ch_slot:
//   - One channel's register, state bit and counter.
//   - Ports: clk, rst, ld, d, dr_ready -> valid, q, cnt.
//   - Instantiated four times with generate; top holds the decode and the in_ready logic.
// TESTING
// 1. Reset, then send 'ha sel 0, 'hb sel 1, 'hc sel 2, 'hd sel 3 with all out_ready=1
//    -> each word on its channel 1 cycle after acceptance; out_cnt = 1,1,1,1.
// 2. out_ready[2]=0, send 'h3 sel 2 then 'h5 sel 2
//    -> first word accepted; in_ready=0 for the second; out_data[2] holds 'h3 stable.
// 3. Same stall as 2, then send 'h7 sel 0 -> accepted immediately, channel 0 unaffected.
// 4. Channel 1 FULL with out_ready[1]=1; send 'h9 sel 1 in the same cycle
//    -> out_valid[1] stays 1, out_data[1]='h9 next cycle, out_cnt[1] += 1.
// 5. 256 back-to-back words to channel 3 with out_ready=1 -> out_cnt[3] wraps to 0.
// 6. Assert rst while channels 0 and 2 are FULL
//    -> next cycle out_valid=0, out_data=0, all counters 0, in_ready=0 during rst.

Source files
------------

// File: rtl/demux_1_4_stream_pkg.sv
// Shared types for the 1:4 stream demux: channel count, select type and per-slot state.
package demux_pkg;

    localparam int N_CH = 4;

    typedef logic [1:0] ch_sel_t;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

endpackage

// File: rtl/demux_1_4_stream_if.sv
// Bundle of the producer-side and four consumer-side stream signals of the 1:4 demux.
interface demux_1_4_stream_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    import demux_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    ch_sel_t               in_sel;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready;
    logic [N_CH*W-1:0]     out_data;
    logic [N_CH*CNT_W-1:0] out_cnt;

    // The demux itself.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );

    // The environment: producer plus the four consumers.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

endinterface

// File: rtl/demux_1_4_stream_ch_slot.sv
// One output channel: a single-entry word register with EMPTY/FULL state and a
// wrapping delivered-word counter.
module demux_ch_slot
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [W-1:0]     d,
    input  logic             dr_ready,
    output logic             valid,
    output logic [W-1:0]     q,
    output logic [CNT_W-1:0] cnt
);

    ch_state_t        state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dr;

    always_comb begin
        // NOTE: every variable of this block is defaulted first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dr      = (state_q == CH_FULL) && dr_ready;

        // A load into a FULL slot only happens alongside a drain, so it simply reloads.
        case (state_q)
            CH_EMPTY: if (ld)        state_d = CH_FULL;
            CH_FULL:  if (dr && !ld) state_d = CH_EMPTY;
            default:                 state_d = CH_EMPTY;
        endcase

        if (ld) data_d = d;
        if (dr) cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: state is updated with non-blocking assignments; the data register is reset as well because the channel word must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = (state_q == CH_FULL);
    assign q     = data_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// 1:4 stream demux: steers each accepted input word into the one-entry register
// of the channel named by in_sel; channels drain independently.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    demux_1_4_stream_if.slave  bus
);

    logic [N_CH-1:0]            valid_w;
    logic [N_CH-1:0][W-1:0]     data_w;
    logic [N_CH-1:0][CNT_W-1:0] cnt_w;
    logic [N_CH-1:0]            ld;
    logic                       in_ready_w;

    // Readiness looks only at the selected slot, so a stalled consumer never blocks the others.
    always_comb begin
        in_ready_w = !rst && (!valid_w[bus.in_sel] || bus.out_ready[bus.in_sel]);
        ld         = '0;
        for (int k = 0; k < N_CH; k++) begin
            ld[k] = bus.in_valid && in_ready_w && (bus.in_sel == ch_sel_t'(k));
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        demux_ch_slot #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .ld       (ld[k]),
            .d        (bus.in_data),
            .dr_ready (bus.out_ready[k]),
            .valid    (valid_w[k]),
            .q        (data_w[k]),
            .cnt      (cnt_w[k])
        );
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = valid_w;
    assign bus.out_data  = data_w;
    assign bus.out_cnt   = cnt_w;

endmodule
